// File: rtl/coef_scan_reader_if.sv
// Coefficient stream interface between the scan reader and the entropy coder.
//   out_valid    : out_data holds a coefficient
//   out_ready    : consumer accepts when out_valid && out_ready
//   out_data     : quantized coefficient
//   out_scan_pos : scan position of out_data (0 = DC)
//   out_block    : block index of out_data
//   out_last     : final coefficient of the slice
interface coef_scan_reader_if #(
  parameter int unsigned DATA_W = 32
);

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [5:0]        out_scan_pos;
  logic [4:0]        out_block;
  logic              out_last;

  // Producer side (scan reader).
  modport master (
    output out_valid,
    output out_data,
    output out_scan_pos,
    output out_block,
    output out_last,
    input  out_ready
  );

  // Consumer side (entropy coder).
  modport slave (
    input  out_valid,
    input  out_data,
    input  out_scan_pos,
    input  out_block,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/coef_scan_reader.sv
// Streams one slice of quantized coefficients out of the block buffer in
// entropy-coder order: every block's DC term first, then for each AC scan
// position 1..63 that coefficient of every block in block order.
//   clock, reset_n : clock, asynchronous active-low reset
//   start          : one-cycle request, honoured only when idle
//   block_count    : blocks in the slice, sampled at accepted start (clamped)
//   input_data     : flat block buffer, block b raster r*8+c at b*64+r*8+c
//   out_if         : valid/ready coefficient stream (master side)
//   busy           : high from the cycle after accepted start until done
//   done           : one-cycle pulse when the slice has been fully sent
module coef_scan_reader #(
  parameter int unsigned MAX_BLOCKS = 32,
  parameter int unsigned DATA_W     = 32
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                start,
  input  logic [5:0]          block_count,
  input  logic [DATA_W-1:0]   input_data [MAX_BLOCKS*64],
  coef_scan_reader_if.master  out_if,
  output logic                busy,
  output logic                done
);

  localparam int unsigned POS_W  = 6;
  localparam int unsigned BLK_W  = 5;
  localparam int unsigned CNT_W  = 6;
  localparam int unsigned ADDR_W = BLK_W + POS_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [CNT_W-1:0]  n_q;
  logic [CNT_W-1:0]  n_d;
  logic              out_valid_q;
  logic              out_valid_d;
  logic [DATA_W-1:0] out_data_q;
  logic [DATA_W-1:0] out_data_d;
  logic [POS_W-1:0]  out_pos_q;
  logic [POS_W-1:0]  out_pos_d;
  logic [BLK_W-1:0]  out_blk_q;
  logic [BLK_W-1:0]  out_blk_d;
  logic              out_last_q;
  logic              out_last_d;
  logic              busy_d;
  logic              done_d;

  logic [CNT_W-1:0]  n_start;
  logic [BLK_W-1:0]  blk_max;
  logic              blk_wrap;
  logic [POS_W-1:0]  next_pos;
  logic [BLK_W-1:0]  next_blk;
  logic              next_last;
  logic [ADDR_W-1:0] next_addr;
  logic              accept;

  // Zigzag-style scan ROM: scan position -> raster index r*8+c.
  function automatic logic [POS_W-1:0] scan_raster(input logic [POS_W-1:0] pos);
    logic [POS_W-1:0] r;
    case (pos)
      6'd0:  r = 6'd0;   6'd1:  r = 6'd1;   6'd2:  r = 6'd8;   6'd3:  r = 6'd9;
      6'd4:  r = 6'd2;   6'd5:  r = 6'd3;   6'd6:  r = 6'd10;  6'd7:  r = 6'd11;
      6'd8:  r = 6'd16;  6'd9:  r = 6'd17;  6'd10: r = 6'd24;  6'd11: r = 6'd25;
      6'd12: r = 6'd18;  6'd13: r = 6'd19;  6'd14: r = 6'd26;  6'd15: r = 6'd27;
      6'd16: r = 6'd4;   6'd17: r = 6'd5;   6'd18: r = 6'd12;  6'd19: r = 6'd20;
      6'd20: r = 6'd13;  6'd21: r = 6'd6;   6'd22: r = 6'd7;   6'd23: r = 6'd14;
      6'd24: r = 6'd21;  6'd25: r = 6'd28;  6'd26: r = 6'd29;  6'd27: r = 6'd22;
      6'd28: r = 6'd15;  6'd29: r = 6'd23;  6'd30: r = 6'd30;  6'd31: r = 6'd31;
      6'd32: r = 6'd32;  6'd33: r = 6'd33;  6'd34: r = 6'd40;  6'd35: r = 6'd48;
      6'd36: r = 6'd41;  6'd37: r = 6'd34;  6'd38: r = 6'd35;  6'd39: r = 6'd42;
      6'd40: r = 6'd49;  6'd41: r = 6'd56;  6'd42: r = 6'd57;  6'd43: r = 6'd50;
      6'd44: r = 6'd43;  6'd45: r = 6'd36;  6'd46: r = 6'd37;  6'd47: r = 6'd44;
      6'd48: r = 6'd51;  6'd49: r = 6'd58;  6'd50: r = 6'd59;  6'd51: r = 6'd52;
      6'd52: r = 6'd45;  6'd53: r = 6'd38;  6'd54: r = 6'd39;  6'd55: r = 6'd46;
      6'd56: r = 6'd53;  6'd57: r = 6'd60;  6'd58: r = 6'd61;  6'd59: r = 6'd54;
      6'd60: r = 6'd47;  6'd61: r = 6'd55;  6'd62: r = 6'd62;  6'd63: r = 6'd63;
      default: r = pos;
    endcase
    return r;
  endfunction

  // Block count as latched at start, clamped to the buffer capacity.
  assign n_start = (block_count > CNT_W'(MAX_BLOCKS)) ? CNT_W'(MAX_BLOCKS) : block_count;

  // The output register doubles as the (pos, blk) iterator: the next element
  // is derived from the one currently presented.
  assign blk_max   = BLK_W'(n_q - CNT_W'(1));
  assign blk_wrap  = (out_blk_q == blk_max);
  assign next_pos  = blk_wrap ? out_pos_q + POS_W'(1) : out_pos_q;
  assign next_blk  = blk_wrap ? BLK_W'(0) : out_blk_q + BLK_W'(1);
  assign next_last = (next_pos == POS_W'(63)) && (next_blk == blk_max);
  assign next_addr = {next_blk, scan_raster(next_pos)};
  assign accept    = out_valid_q && out_if.out_ready;

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = (n_start != CNT_W'(0)) ? ST_STREAM : ST_DONE;
        end
      end
      ST_STREAM: begin
        if (accept && out_last_q) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output/datapath next values; everything here lands in a register.
  always_comb begin
    n_d         = n_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_pos_d   = out_pos_q;
    out_blk_d   = out_blk_q;
    out_last_d  = out_last_q;
    busy_d      = (state_d == ST_STREAM);
    done_d      = (state_d == ST_DONE);
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          n_d = n_start;
          // First element (pos 0, blk 0) is presented the cycle after start.
          if (n_start != CNT_W'(0)) begin
            out_valid_d = 1'b1;
            out_data_d  = input_data[ADDR_W'(0)];
            out_pos_d   = POS_W'(0);
            out_blk_d   = BLK_W'(0);
            out_last_d  = 1'b0;
          end
        end
      end
      ST_STREAM: begin
        if (!out_valid_q || out_if.out_ready) begin
          if (out_valid_q && out_last_q) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
          end else begin
            out_valid_d = 1'b1;
            out_data_d  = input_data[next_addr];
            out_pos_d   = next_pos;
            out_blk_d   = next_blk;
            out_last_d  = next_last;
          end
        end
      end
      default: begin
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      n_q         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_pos_q   <= '0;
      out_blk_q   <= '0;
      out_last_q  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      n_q         <= n_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_pos_q   <= out_pos_d;
      out_blk_q   <= out_blk_d;
      out_last_q  <= out_last_d;
      busy        <= busy_d;
      done        <= done_d;
    end
  end

  assign out_if.out_valid    = out_valid_q;
  assign out_if.out_data     = out_data_q;
  assign out_if.out_scan_pos = out_pos_q;
  assign out_if.out_block    = out_blk_q;
  assign out_if.out_last     = out_last_q;

endmodule

// File: tb/tb_coef_scan_reader.sv
// Scoreboard bench for coef_scan_reader: stimulus pushes the expected beat
// sequence of each slice, a negedge monitor pops and compares every handshake.
module tb_coef_scan_reader;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned MAX_BLOCKS = 32;
  localparam int          DEPTH      = 2048;

  typedef struct packed {
    logic [31:0] data;
    logic [5:0]  pos;
    logic [4:0]  blk;
    logic        last;
  } beat_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  block_count = 6'd0;
  logic        busy;
  logic        done;
  logic [31:0] mem [DEPTH];

  coef_scan_reader_if #(.DATA_W(DATA_W)) bus ();

  coef_scan_reader #(
    .MAX_BLOCKS (MAX_BLOCKS),
    .DATA_W     (DATA_W)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .block_count (block_count),
    .input_data  (mem),
    .out_if      (bus),
    .busy        (busy),
    .done        (done)
  );

  always #5 clock = ~clock;

  int    checks = 0;
  int    failures = 0;
  beat_t exp_q[$];
  int    hs_count = 0;
  int    stall_cycles = 0;
  int    cyc = 0;
  int    last_cyc = 0;
  bit    done_due = 1'b0;
  bit    stall_prev = 1'b0;
  beat_t held;

  int scan_tb [64] = '{
     0,  1,  8,  9,  2,  3, 10, 11, 16, 17, 24, 25, 18, 19, 26, 27,
     4,  5, 12, 20, 13,  6,  7, 14, 21, 28, 29, 22, 15, 23, 30, 31,
    32, 33, 40, 48, 41, 34, 35, 42, 49, 56, 57, 50, 43, 36, 37, 44,
    51, 58, 59, 52, 45, 38, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic beat_t cur_beat();
    beat_t b;
    b = {bus.out_data, bus.out_scan_pos, bus.out_block, bus.out_last};
    return b;
  endfunction

  // Monitor: handshakes, done pulse timing, stall stability.
  always @(negedge clock) begin
    beat_t c;
    beat_t e;
    c = cur_beat();
    if (!reset_n) begin
      done_due   = 1'b0;
      stall_prev = 1'b0;
    end else begin
      if (done_due) begin
        chk("done_pulse", 64'({done, busy, bus.out_valid}), 64'(3'b100));
        done_due = 1'b0;
      end else begin
        chk("no_stray_done", 64'(done), 64'(0));
      end
      if (bus.out_valid && !bus.out_ready) begin
        if (stall_prev) chk("stall_hold", 64'(c), 64'(held));
        stall_prev = 1'b1;
        held = c;
        stall_cycles++;
      end else begin
        stall_prev = 1'b0;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL extra_beat got=%h exp=none", c);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("beat%0d", hs_count), 64'(c), 64'(e));
          if (e.last) begin
            done_due = 1'b1;
            last_cyc = cyc;
          end
        end
        hs_count++;
      end
    end
  end

  task automatic run_slice(input int bc, input int stall_at, input int again_at,
                           input int reset_at, input string tag);
    int    n;
    int    k;
    int    budget;
    bit    stalled;
    bit    again;
    bit    rst;
    beat_t e;
    n = (bc > 32) ? 32 : bc;
    for (int p = 0; p < 64; p++) begin
      for (int b = 0; b < n; b++) begin
        e.data = mem[b*64 + scan_tb[p]];
        e.pos  = 6'(p);
        e.blk  = 5'(b);
        e.last = (p == 63) && (b == n - 1);
        exp_q.push_back(e);
      end
    end
    hs_count = 0;
    stall_cycles = 0;
    stalled = 1'b0;
    again = 1'b0;
    rst = 1'b0;
    @(posedge clock); #1;
    start = 1'b1;
    block_count = 6'(bc);
    @(posedge clock); #1;
    start = 1'b0;
    k = cyc;
    chk({tag, "_first_cycle"}, 64'({busy, bus.out_valid}), (n > 0) ? 64'(2'b11) : 64'(2'b00));
    if (n == 0) done_due = 1'b1;
    budget = n * 64 + 50;
    while (exp_q.size() > 0 && budget > 0) begin
      if (stall_at >= 0 && !stalled && hs_count == stall_at) begin
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        bus.out_ready = 1'b1;
        stalled = 1'b1;
      end else if (again_at >= 0 && !again && hs_count == again_at) begin
        start = 1'b1;
        block_count = 6'd7;
        @(posedge clock); #1;
        start = 1'b0;
        again = 1'b1;
      end else if (reset_at >= 0 && hs_count == reset_at) begin
        reset_n = 1'b0;
        #1;
        chk({tag, "_reset_outputs"},
            64'({bus.out_valid, bus.out_last, busy, done, bus.out_data, bus.out_scan_pos, bus.out_block}),
            64'(0));
        exp_q.delete();
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        rst = 1'b1;
        break;
      end else begin
        @(posedge clock); #1;
      end
      budget--;
    end
    if (!rst) begin
      if (exp_q.size() > 0) begin
        chk({tag, "_timeout_remaining"}, 64'(exp_q.size()), 64'(0));
        exp_q.delete();
      end
      if (n > 0) chk({tag, "_stream_cycles"}, 64'(last_cyc - k), 64'(n * 64 - 1 + (stalled ? 3 : 0)));
      if (stalled) chk({tag, "_stall_cycles"}, 64'(stall_cycles), 64'(3));
    end
    repeat (3) @(posedge clock);
    #1;
    chk({tag, "_idle_after"}, 64'({busy, bus.out_valid, done}), 64'(0));
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'(i);
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_state",
        64'({bus.out_valid, bus.out_last, busy, done, bus.out_data, bus.out_scan_pos, bus.out_block}),
        64'(0));
    reset_n = 1'b1;

    run_slice(1, -1, -1, -1, "n1");
    run_slice(2, -1, -1, -1, "n2");
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'hA500_0000 ^ 32'(i * 7);
    run_slice(3, 10, -1, -1, "n3_stall");
    run_slice(0, -1, -1, -1, "n0");
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'(i);
    run_slice(40, -1, -1, -1, "n40_clamp");
    run_slice(4, -1, 20, -1, "restart_ignored");
    run_slice(2, -1, -1, 50, "reset_mid");
    run_slice(1, -1, -1, -1, "after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
